// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and FSM encodings for the data-memory access path
package mem_pkg;
  localparam int DM_AW_DEF = 10;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;
endpackage

// File: rtl/dm_lane_mux.sv
// dm_lane_mux: big-endian sub-word load extract/extend and store merge
module dm_lane_mux import mem_pkg::*; (
  input  logic [31:0] old_word,
  input  logic [15:0] wsub,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] aligned, mask, lane;
  always_comb begin
    sh = {off, 3'b000};
    // shifting left by the offset brings the addressed lane to the top bits
    aligned = old_word << sh;
    rdata = size == SZ_W ? old_word :
            size == SZ_H ? {{16{sign_ext & aligned[31]}}, aligned[31:16]} :
                           {{24{sign_ext & aligned[31]}}, aligned[31:24]};
    mask = (size == SZ_H ? 32'hFFFF_0000 : 32'hFF00_0000) >> sh;
    lane = (size == SZ_H ? {wsub, 16'h0} : {wsub[7:0], 24'h0}) >> sh;
    merged = (old_word & ~mask) | (lane & mask);
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store unit with read-modify-write sub-word stores and sticky error capture
module dm_access_ctrl import mem_pkg::*; #(
  parameter int DM_AW = DM_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             misalign,
  output logic             err_sticky,
  output logic [31:0]      err_addr,
  input  logic             err_clr,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);
  logic [0:0]       state_q, state_d;
  logic [31:0]      merge_q, err_addr_q, lane_rdata, merged;
  logic [DM_AW-1:0] addr_q;
  logic             err_sticky_q, idle, illegal, bad, sub_st, word_st;
  dm_lane_mux u_lane (
    .old_word(dm_dout),
    .wsub    (wdata[15:0]),
    .off     (addr[1:0]),
    .size    (size),
    .sign_ext(sign_ext),
    .rdata   (lane_rdata),
    .merged  (merged)
  );
  always_comb begin
    idle = state_q == IDLE;
    illegal = size == 2'b11 || (size == SZ_W && addr[1:0] != 2'b00) || (size == SZ_H && addr[0]);
    bad = !rst && idle && req && illegal;
    sub_st = !rst && idle && req && wr && !illegal && size != SZ_W;
    word_st = !rst && idle && req && wr && !illegal && size == SZ_W;
    state_d = sub_st ? MERGE : IDLE;
    stall = sub_st;
    misalign = bad;
    // MERGE writes only latched data, regardless of what the CPU drives now
    dm_we = !rst && (!idle || word_st);
    dm_addr = idle ? addr[DM_AW+1:2] : addr_q;
    dm_din = idle ? wdata : merge_q;
    rdata = (rst || bad) ? '0 : lane_rdata;
    err_sticky = err_sticky_q;
    err_addr = err_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= '0;
      addr_q <= '0;
      err_sticky_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (sub_st) begin
        merge_q <= merged;
        addr_q <= addr[DM_AW+1:2];
      end
      if (bad) begin
        err_sticky_q <= 1'b1;
        if (!err_sticky_q || err_clr) err_addr_q <= addr;
      end else if (err_clr) begin
        err_sticky_q <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench with a byte-array reference model of memory and error state
module tb_dm_access_ctrl;
  import mem_pkg::*;
  logic clk = 1'b0, rst, req, wr, sign_ext, err_clr;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata, err_addr, dm_din, dm_dout;
  logic stall, misalign, err_sticky, dm_we;
  logic [9:0] dm_addr;
  int total = 0, bad = 0;
  logic [31:0] mem [1024];
  logic [7:0] rb [4096];
  bit ref_sticky = 0;
  logic [31:0] ref_eaddr = 0;
  typedef struct {
    bit chk_rd;
    logic [31:0] rd;
    bit mis;
    bit sticky;
    logic [31:0] eaddr;
    int stalls;
    int wes;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int st_c = 0, we_c = 0;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
    .err_sticky(err_sticky), .err_addr(err_addr), .err_clr(err_clr),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rword(input int w);
    return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
  endfunction

  task automatic do_op(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] d, input bit clr);
    exp_t e;
    int o, n;
    bit ill;
    o = int'(a[11:0]);
    ill = sz == 2'b11 || (sz == SZ_W && a[1:0] != 2'b00) || (sz == SZ_H && a[0]);
    e.sticky = ref_sticky;
    e.eaddr = ref_eaddr;
    e.mis = ill;
    e.chk_rd = ill || !w;
    e.stalls = (!ill && w && sz != SZ_W) ? 1 : 0;
    e.wes = (!ill && w) ? 1 : 0;
    e.rd = 0;
    if (!ill && !w) begin
      if (sz == SZ_B) e.rd = sx ? {{24{rb[o][7]}}, rb[o]} : {24'h0, rb[o]};
      else if (sz == SZ_H) e.rd = sx ? {{16{rb[o][7]}}, rb[o], rb[o+1]} : {16'h0, rb[o], rb[o+1]};
      else e.rd = rword(o / 4);
    end
    if (!ill && w) begin
      if (sz == SZ_B) rb[o] = d[7:0];
      else if (sz == SZ_H) begin rb[o] = d[15:8]; rb[o+1] = d[7:0]; end
      else begin rb[o] = d[31:24]; rb[o+1] = d[23:16]; rb[o+2] = d[15:8]; rb[o+3] = d[7:0]; end
    end
    if (ill) begin
      if (!ref_sticky || clr) ref_eaddr = a;
      ref_sticky = 1;
    end else if (clr) begin
      ref_sticky = 0;
      ref_eaddr = 0;
    end
    q.push_back(e);
    req = 1; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d; err_clr = clr;
    @(negedge clk);
    n = 0;
    while (stall && n < 5) begin @(negedge clk); n++; end
    if (n >= 5) begin
      total++; bad++;
      $display("FAIL stall_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    err_clr = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      st_c = 0; we_c = 0;
    end else begin
      if (dm_we) we_c++;
      if (req && stall) st_c++;
      else if (req) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion addr=%h", addr);
        end else begin
          m_e = q.pop_front();
          chk("misalign", {31'h0, misalign}, {31'h0, m_e.mis});
          if (m_e.chk_rd) chk("rdata", rdata, m_e.rd);
          chk("err_sticky", {31'h0, err_sticky}, {31'h0, m_e.sticky});
          chk("err_addr", err_addr, m_e.eaddr);
          chk("stall_cycles", st_c, m_e.stalls);
          chk("we_cycles", we_c, m_e.wes);
        end
        st_c = 0; we_c = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a;
    bit w, clr;
    logic [1:0] sz;
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    for (int i = 0; i < 4096; i++) rb[i] = 0;
    rst = 1; req = 1; wr = 0; size = 2'b11; sign_ext = 1; addr = 32'h13; wdata = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", {31'h0, stall}, 0);
    chk("rst_we", {31'h0, dm_we}, 0);
    chk("rst_misalign", {31'h0, misalign}, 0);
    chk("rst_sticky", {31'h0, err_sticky}, 0);
    chk("rst_err_addr", err_addr, 0);
    @(posedge clk); #1;
    rst = 0; req = 1; wr = 1; size = SZ_B; addr = 32'h30; wdata = 32'h55;
    @(negedge clk);
    chk("rm_stall1", {31'h0, stall}, 1);
    chk("rm_we1", {31'h0, dm_we}, 0);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rm_we_rst", {31'h0, dm_we}, 0);
    chk("rm_stall_rst", {31'h0, stall}, 0);
    @(posedge clk); #1;
    rst = 0; req = 0;
    @(negedge clk);
    chk("rm_we_idle", {31'h0, dm_we}, 0);
    chk("rm_stall_idle", {31'h0, stall}, 0);
    chk("rm_mem30", mem[12], 0);
    @(posedge clk); #1;
    do_op(1, SZ_W, 0, 32'h10, 32'h12345678, 0);
    do_op(0, SZ_W, 0, 32'h10, 32'h0, 0);
    do_op(1, SZ_W, 0, 32'h20, 32'hAABBCCDD, 0);
    do_op(1, SZ_B, 0, 32'h21, 32'hFFFFFF11, 0);
    do_op(0, SZ_W, 0, 32'h20, 32'h0, 0);
    do_op(1, SZ_H, 0, 32'h22, 32'h1234BEEF, 0);
    req = 0;
    @(negedge clk);
    chk("mem20", mem[8], 32'hAA11BEEF);
    @(posedge clk); #1;
    do_op(0, SZ_B, 1, 32'h20, 0, 0);
    do_op(0, SZ_B, 0, 32'h20, 0, 0);
    do_op(0, SZ_H, 1, 32'h22, 0, 0);
    do_op(0, SZ_H, 0, 32'h22, 0, 0);
    do_op(0, SZ_W, 0, 32'h13, 0, 0);
    do_op(1, SZ_H, 0, 32'h05, 32'h9999, 0);
    do_op(0, SZ_W, 0, 32'h10, 0, 1);
    do_op(0, SZ_W, 0, 32'h20, 0, 0);
    do_op(1, 2'b11, 0, 32'h44, 0, 0);
    do_op(0, SZ_H, 0, 32'h47, 0, 1);
    do_op(0, SZ_W, 0, 32'h1020, 0, 0);
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      w = r[0];
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      a = {(r[3:1] == 0) ? r[31:12] : 20'h0, 12'($urandom_range(0, 63))};
      clr = ($urandom % 8 == 0) && !(w && sz != SZ_W && sz != 2'b11 &&
            !(sz == SZ_H && a[0]));
      do_op(w, sz, r[4], a, $urandom, clr);
      if (r[6:5] == 0) begin req = 0; @(posedge clk); #1; end
    end
    req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 1024; i++) chk($sformatf("mem[%0d]", i), mem[i], rword(i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Load/store unit between the datapath's MEM stage and the 4 KB word-addressed data memory (dm_4k).
- Provides byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) on top of a memory that only reads and writes whole words.
- Sub-word stores are a registered two-cycle read-modify-write, with a stall back to the PC/control.
- Misaligned and illegal accesses are blocked and latched in a sticky status register.

Parameters:
- DM_AW, 10, word-address width toward data memory (dm_addr = addr[DM_AW+1:2]).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  memory access valid this cycle; held by the CPU while stall=1.
- wr  input  1  1=store, 0=load.
- size  input  2  00=byte, 01=half, 10=word, 11=illegal.
- sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend the sub-word result.
- addr  input  32  byte address from the ALU; bits 31:DM_AW+2 ignored.
- wdata  input  32  store data; the sub-word is taken from the LSBs.
- rdata  output  32  load result, combinational.
- stall  output  1  hold PC/pipeline this cycle.
- misalign  output  1  single-cycle pulse for a rejected access.
- err_sticky  output  1  set by any rejected access; cleared by rst or err_clr.
- err_addr  output  32  address of the first rejected access since the last clear.
- err_clr  input  1  clears err_sticky and err_addr.
- dm_addr  output  DM_AW  word address to data memory.
- dm_din  output  32  write data to data memory.
- dm_we  output  1  data memory write enable.
- dm_dout  input  32  data memory read data (combinational read).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Byte order is big-endian: byte offset 0 maps to bits 31:24; halfword offset 0 maps to bits 31:16.
- Reset values:
  - FSM=IDLE; stall=0; dm_we=0; misalign=0.
  - err_sticky=0; err_addr=0.
  - rdata is don't-care, but is driven 0 while rst=1.
- Legality check:
  - size=11 is illegal.
  - Word access with addr[1:0]!=0 is illegal.
  - Half access with addr[0]!=0 is illegal.
  - On an illegal access with req=1: misalign=1 in the same cycle, dm_we=0, rdata=0, stall=0.
  - On the next edge err_sticky<=1. err_addr<=addr only if err_sticky was 0 (first error wins).
  - If err_clr and a new error occur in the same cycle, the new error wins: sticky=1, err_addr=the new addr.
- Loads (0-cycle latency, no stall):
  - dm_addr=addr[11:2].
  - rdata is the selected byte/half of dm_dout, extended per sign_ext; a word load passes dm_dout through.
- Word store (sw):
  - Single cycle, no stall.
  - dm_we=req, dm_din=wdata, dm_addr=addr[11:2].
- Sub-word store (sb/sh) FSM, states IDLE -> MERGE -> IDLE:
  - IDLE, legal sub-word store with req=1:
    - stall=1, dm_we=0, dm_addr=addr[11:2].
    - On the edge: latch merged word (dm_dout with the target byte/half replaced by wdata[7:0]/[15:0]) into merge_q; latch the word address into addr_q; go to MERGE.
  - MERGE: stall=0, dm_we=1, dm_addr=addr_q, dm_din=merge_q; the edge returns to IDLE.
  - Total latency 2 cycles. The CPU advances on the MERGE edge.
  - In MERGE the write uses only latched values. A req drop or input change does not abort it, and a new access is not accepted in this cycle.
- Reset mid-operation: rst=1 while in MERGE forces dm_we=0 in that cycle and returns to IDLE. The partial store is discarded and memory is unchanged.
- req=0 in IDLE: dm_we=0, stall=0, no state change; rdata still reflects addr (harmless).
- Addresses at or above 4 KB alias modulo 4 KB. No error is raised for them.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W.
  - FSM state encoding (IDLE, MERGE).
  - DM_AW default.
- One natural sub-module, dm_lane_mux (combinational), containing:
  - load extract/extend: dm_dout, offset, size, sign_ext -> rdata.
  - store merge: old word, wdata, offset, size -> merged word.

Test Plan:
- Word round trip: sw 0x12345678 @0x010, then lw @0x010 -> rdata=0x12345678; dm_we high exactly one cycle; stall never 1.
- Byte store: word @0x020 = 0xAABBCCDD, sb 0x11 @0x021 -> stall=1 for cycle 1, dm_we=1 in cycle 2, memory word = 0xAA11CCDD.
- Half store, big-endian: sh 0xBEEF @0x022 on 0xAA11CCDD -> 0xAA11BEEF.
- Signed/unsigned loads on 0xAA11BEEF:
  - lb @0x020 -> 0xFFFFFFAA; lbu @0x020 -> 0x000000AA.
  - lh @0x022 -> 0xFFFFBEEF; lhu @0x022 -> 0x0000BEEF.
- Misalign: lw @0x013 -> misalign pulse, rdata=0, no write, err_sticky=1, err_addr=0x13. Then sh @0x005 -> err_addr stays 0x13. err_clr -> sticky=0, err_addr=0.
- Reset in MERGE: sb 0x55 @0x030 (old 0x00000000), rst=1 in cycle 2 -> dm_we=0, word stays 0x00000000, FSM=IDLE, stall=0.
